// File: rtl/fft_mag_stream_if.sv
// Sample/bin stream bundle between an FFT core and the magnitude estimator.
// The master drives complex samples in; the slave returns magnitude bins.
interface fft_mag_stream_if #(
    parameter int DWIDTH = 12,
    parameter int RWIDTH = 10
);
    logic                     ivalid;
    logic signed [DWIDTH-1:0] ire;
    logic signed [DWIDTH-1:0] iim;
    logic                     ilast;
    logic                     ovalid;
    logic [DWIDTH-1:0]        odata;
    logic [RWIDTH-1:0]        oaddr;
    logic                     olast;
    logic                     oerr;

    modport master (
        output ivalid, ire, iim, ilast,
        input  ovalid, odata, oaddr, olast, oerr
    );

    modport slave (
        input  ivalid, ire, iim, ilast,
        output ovalid, odata, oaddr, olast, oerr
    );
endinterface

// File: rtl/fft_mag_stream.sv
// Streaming alpha-max/beta-min magnitude estimator for FFT output with bin
// numbering, half-spectrum selection and frame-length checking.
module fft_mag_stream #(
    parameter int DWIDTH   = 12,
    parameter int RWIDTH   = 10,
    parameter int FRAMELEN = 1024,
    parameter int HALF     = 1
) (
    input logic              clock,
    input logic              reset_n,
    fft_mag_stream_if.slave  bus
);
    localparam logic [RWIDTH-1:0] LAST_BIN      = RWIDTH'(FRAMELEN - 1);
    localparam logic [RWIDTH-1:0] HALF_LAST_BIN = RWIDTH'(FRAMELEN / 2 - 1);

    logic [RWIDTH-1:0] cnt_reg, cnt_next;
    logic              at_end, frame_err, in_range, emit_last;

    always_comb begin
        at_end    = (cnt_reg == LAST_BIN);
        frame_err = bus.ivalid && (bus.ilast != at_end);
        cnt_next  = cnt_reg;
        if (bus.ivalid) begin
            cnt_next = (bus.ilast || at_end) ? '0 : cnt_reg + 1'b1;
        end
    end

    // In half mode the upper bins never leave the block, so a short frame
    // must close on its ilast sample or on the last lower-half bin.
    generate
        if (HALF != 0) begin : g_half
            assign in_range  = (cnt_reg <= HALF_LAST_BIN);
            assign emit_last = bus.ilast || (cnt_reg == HALF_LAST_BIN);
        end else begin : g_full
            assign in_range  = 1'b1;
            assign emit_last = bus.ilast || at_end;
        end
    endgenerate

    // Two's-complement magnitude fits DWIDTH unsigned bits, including -2^(DWIDTH-1).
    logic [1:0][DWIDTH-1:0] abs_next;
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
        logic [DWIDTH-1:0] comp;
        assign comp         = (gi == 0) ? bus.ire : bus.iim;
        assign abs_next[gi] = comp[DWIDTH-1] ? (~comp + 1'b1) : comp;
    end

    // S1: absolute values
    logic [1:0][DWIDTH-1:0] s1_abs_reg;
    logic [RWIDTH-1:0]      s1_addr_reg;
    logic                   s1_valid_reg, s1_last_reg, oerr_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_abs_reg   <= '0;
            s1_addr_reg  <= '0;
            oerr_reg     <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            s1_valid_reg <= bus.ivalid && in_range;
            oerr_reg     <= frame_err;
            if (bus.ivalid) begin
                s1_abs_reg  <= abs_next;
                s1_addr_reg <= cnt_reg;
                s1_last_reg <= emit_last;
            end
        end
    end

    // S2: max/min sort
    logic [DWIDTH-1:0] s2_max_reg, s2_min_reg, max_next, min_next;
    logic [RWIDTH-1:0] s2_addr_reg;
    logic              s2_valid_reg, s2_last_reg;

    always_comb begin
        max_next = s1_abs_reg[0];
        min_next = s1_abs_reg[1];
        if (s1_abs_reg[1] > s1_abs_reg[0]) begin
            max_next = s1_abs_reg[1];
            min_next = s1_abs_reg[0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_max_reg   <= '0;
            s2_min_reg   <= '0;
            s2_addr_reg  <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_max_reg  <= max_next;
                s2_min_reg  <= min_next;
                s2_addr_reg <= s1_addr_reg;
                s2_last_reg <= s1_last_reg;
            end
        end
    end

    // S3: mx + 3/8 mn peaks at 1.375 * 2^(DWIDTH-1), so DWIDTH bits never wrap.
    logic [DWIDTH-1:0] mag_next, odata_reg;
    logic [RWIDTH-1:0] oaddr_reg;
    logic              ovalid_reg, olast_reg;

    assign mag_next = s2_max_reg + (s2_min_reg >> 2) + (s2_min_reg >> 3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovalid_reg <= 1'b0;
            olast_reg  <= 1'b0;
            odata_reg  <= '0;
            oaddr_reg  <= '0;
        end else begin
            ovalid_reg <= s2_valid_reg;
            olast_reg  <= s2_valid_reg && s2_last_reg;
            if (s2_valid_reg) begin
                odata_reg <= mag_next;
                oaddr_reg <= s2_addr_reg;
            end
        end
    end

    assign bus.ovalid = ovalid_reg;
    assign bus.odata  = odata_reg;
    assign bus.oaddr  = oaddr_reg;
    assign bus.olast  = olast_reg;
    assign bus.oerr   = oerr_reg;
endmodule

// File: doc/fft_mag_stream.md
FFT_MAG_STREAM -- requirements
Module: fft_mag_stream

Interface
REQ-001 SHALL have parameter DWIDTH, default 12, width of signed FFT real/imag inputs and of unsigned magnitude output.
REQ-002 SHALL have parameter RWIDTH, default 10, bin address width.
REQ-003 SHALL have parameter FRAMELEN, default 1024, FFT points per frame; FRAMELEN <= 2^RWIDTH, even.
REQ-004 SHALL have parameter HALF, default 1; 1 = emit bins 0..FRAMELEN/2-1 only, 0 = emit all bins.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ivalid  input  1  input sample qualifier; gaps allowed; no backpressure.
REQ-008 SHALL have port ire  input  DWIDTH  signed real part.
REQ-009 SHALL have port iim  input  DWIDTH  signed imaginary part.
REQ-010 SHALL have port ilast  input  1  marks last sample of frame; ignored when ivalid=0.
REQ-011 SHALL have port ovalid  output  1  output qualifier, feeds downstream peak search ivalid.
REQ-012 SHALL have port odata  output  DWIDTH  unsigned magnitude estimate.
REQ-013 SHALL have port oaddr  output  RWIDTH  bin index of odata.
REQ-014 SHALL have port olast  output  1  high with the last emitted bin of a frame.
REQ-015 SHALL have port oerr  output  1  one-cycle framing-error pulse.

Function
REQ-016 SHALL compute magnitude as mx + (mn>>2) + (mn>>3), mx = max(|ire|,|iim|), mn = min(|ire|,|iim|), absolute values held unsigned DWIDTH bits (|-2^(DWIDTH-1)| = 2^(DWIDTH-1), no saturation needed); sum computed DWIDTH+1 bits, result always < 2^DWIDTH, truncated to DWIDTH.
REQ-017 SHALL be a 3-stage pipeline: S1 absolute values, S2 max/min sort, S3 sum; each stage registers data, address, last flag and a valid bit.
REQ-018 SHALL assert ovalid exactly 3 clock cycles after the ivalid cycle that produced it; gaps in ivalid reproduced as gaps in ovalid.
REQ-019 SHALL hold odata/oaddr/olast at last values when ovalid=0; olast=0 whenever ovalid=0.
REQ-020 SHALL keep bin counter cnt (RWIDTH bits): sample accepted when ivalid=1 gets address cnt; cnt increments per accepted sample.
REQ-021 SHALL reset cnt to 0 after an accepted sample with ilast=1, regardless of cnt value.
REQ-022 SHALL reset cnt to 0 after an accepted sample with cnt = FRAMELEN-1, regardless of ilast.
REQ-023 SHALL pulse oerr for one cycle, 1 cycle after an accepted sample where (ilast=1 and cnt != FRAMELEN-1) or (ilast=0 and cnt = FRAMELEN-1); output data path unaffected.
REQ-024 SHALL, HALF=1, suppress ovalid for samples with address >= FRAMELEN/2, and assert olast with address FRAMELEN/2-1.
REQ-025 SHALL, HALF=0, assert olast with any sample accepted with ilast=1 or address FRAMELEN-1.
REQ-026 SHALL, HALF=1 and ilast before bin FRAMELEN/2-1 (short frame), emit olast on the ilast sample itself.
REQ-027 SHALL contain no combinational path from any input to any output.

Reset
REQ-028 SHALL, on reset_n low, immediately clear cnt, all pipeline valid bits, ovalid, olast, oerr, odata, oaddr to 0.
REQ-029 SHALL discard in-flight samples on reset mid-frame; first accepted sample after release has address 0.

Verification
REQ-030 SHALL verify: ire=300, iim=-400 single ivalid at cycle t -> ovalid at t+3, odata=512, oaddr=0.
REQ-031 SHALL verify: ire=-2048, iim=-2048 -> odata=2816; ire=-2048, iim=0 -> odata=2048; ire=0, iim=0 -> odata=0.
REQ-032 SHALL verify: HALF=1, 1024 samples with ilast on 1024th -> 512 ovalid pulses, oaddr 0..511, olast only at 511, oerr never high; next frame starts at oaddr 0.
REQ-033 SHALL verify: ilast on sample with cnt=99 -> oerr pulse one cycle later, olast with oaddr=99, next sample oaddr=0.
REQ-034 SHALL verify: random ivalid gaps (~50% duty) -> ovalid pattern equals ivalid delayed 3 cycles (addresses < 512), oaddr contiguous.
REQ-035 SHALL verify: reset_n pulsed low at cnt=200 with 3 samples in flight -> no ovalid after release until new input; first output oaddr=0.
